// File: rtl/bsg_manycore_pkg.sv
// Shared types for the ruche_x edge endpoint: edge state encoding, packet op
// codes, packet-width helpers and the response-expecting op predicate.
package bsg_manycore_pkg;

    typedef enum logic [1:0] {
        E_RUCHE_RESET   = 2'd0,
        E_RUCHE_ACTIVE  = 2'd1,
        E_RUCHE_DRAIN   = 2'd2,
        E_RUCHE_DRAINED = 2'd3
    } ruche_edge_state_e;

    typedef enum logic [1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1,
        e_remote_amo   = 2'd2,
        e_cache_op     = 2'd3
    } bsg_manycore_packet_op_e;

    localparam int packet_op_width_gp   = 2;
    localparam int return_type_width_gp = 2;

    // fwd packet, MSB..LSB: {addr, op, non_returning, data, src_y, src_x, y_cord, x_cord}
    function automatic int fwd_packet_width(input int a, input int d, input int x, input int y);
        return a + packet_op_width_gp + 1 + d + 2*y + 2*x;
    endfunction

    function automatic int link_fwd_packet_width(input int a, input int d, input int x, input int y);
        return fwd_packet_width(a, d, x, y) - y;
    endfunction

    // rev packet, MSB..LSB: {return_type, data, y_cord, x_cord}
    function automatic int rev_packet_width(input int d, input int x, input int y);
        return return_type_width_gp + d + y + x;
    endfunction

    function automatic int link_rev_packet_width(input int d, input int x, input int y);
        return rev_packet_width(d, x, y) - y;
    endfunction

    function automatic int ruche_x_link_sif_width(input int a, input int d, input int x, input int y);
        return link_fwd_packet_width(a, d, x, y) + link_rev_packet_width(d, x, y) + 4;
    endfunction

    // Stores and packets flagged non-returning never produce a rev response.
    function automatic logic expects_response(input bsg_manycore_packet_op_e op,
                                              input logic non_returning);
        return (op != e_remote_store) && !non_returning;
    endfunction

endpackage

// File: rtl/bsg_manycore_ruche_x_edge_fifo.sv
// Two-entry ready/valid FIFO with asynchronous active-low reset; enqueue only
// when not full, no bypass from input to output.
module bsg_manycore_ruche_x_edge_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_q [2];
    logic [width_p-1:0] mem_d [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               enq, deq;

    assign ready_o = (count_q != 2'd2);
    assign v_o     = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(enq) - 2'(deq);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bsg_manycore_ruche_x_edge_endpoint.sv
// Ruche_x pod-edge endpoint: re-injects src_y on received fwd packets, strips dest_y on
// sent rev packets, counts outstanding requests and supports a drain handshake.
// Optional BSG_MANYCORE_RUCHE_EDGE_Y_CHECK_EN adds a sticky bad_y_r flag for rev dest_y != my_y_i.
module bsg_manycore_ruche_x_edge_endpoint
    import bsg_manycore_pkg::*;
#(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 7,
    parameter int y_cord_width_p    = 7,
    parameter int max_out_credits_p = 32,
    localparam int fwd_width_lp      = fwd_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int link_fwd_width_lp = link_fwd_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int rev_width_lp      = rev_packet_width(data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int link_rev_width_lp = link_rev_packet_width(data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int sif_width_lp      = ruche_x_link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int cnt_width_lp      = $clog2(max_out_credits_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic [sif_width_lp-1:0]   ruche_link_i,
    output logic [sif_width_lp-1:0]   ruche_link_o,
    output logic                      fwd_v_o,
    output logic [fwd_width_lp-1:0]   fwd_data_o,
    input  logic                      fwd_yumi_i,
    input  logic                      rev_v_i,
    input  logic [rev_width_lp-1:0]   rev_data_i,
    output logic                      rev_ready_o,
    input  logic                      drain_i,
    output logic                      drained_o,
    output logic [cnt_width_lp-1:0]   outstanding_o
);

    localparam int off_src_y_lp  = 2*x_cord_width_p + y_cord_width_p;
    localparam int off_nr_lp     = 2*x_cord_width_p + 2*y_cord_width_p + data_width_p;
    localparam int off_op_lp     = off_nr_lp + 1;
    localparam int off_rev_y_lp  = x_cord_width_p;
    localparam int off_rev_hi_lp = x_cord_width_p + y_cord_width_p;
    localparam logic [cnt_width_lp-1:0] max_cnt_lp = cnt_width_lp'(max_out_credits_p);

    ruche_edge_state_e             state_q, state_d;
    logic [1:0]                    rst_sync_q, rst_sync_d;
    logic                          rst_n_sync;
    logic [cnt_width_lp-1:0]       outstanding_q, outstanding_d;
    logic                          drained_q, drained_d;

    logic                          link_fwd_v, link_fwd_ready_and;
    logic [link_fwd_width_lp-1:0]  link_fwd_data;
    logic                          link_rev_ready_and;
    logic [fwd_width_lp-1:0]       fwd_injected;
    logic                          fwd_fifo_ready;
    logic                          rev_fifo_ready, rev_fifo_v, rev_enq;
    logic [rev_width_lp-1:0]       rev_fifo_data;
    logic [link_rev_width_lp-1:0]  rev_link_data;
    logic                          cnt_inc, cnt_dec, link_idle;
    logic                          unused_link_bits;

    // Asserts asynchronously with reset_n_i, releases two clocks after it.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_sync = rst_sync_q[1];

    assign link_fwd_v         = ruche_link_i[sif_width_lp-1];
    assign link_fwd_data      = ruche_link_i[sif_width_lp-2 -: link_fwd_width_lp];
    assign link_rev_ready_and = ruche_link_i[0];
    assign unused_link_bits   = ^{ruche_link_i[link_rev_width_lp+2:1],
                                  rev_fifo_data[off_rev_y_lp +: y_cord_width_p]};

    assign fwd_injected = {link_fwd_data[link_fwd_width_lp-1:off_src_y_lp], my_y_i,
                           link_fwd_data[off_src_y_lp-1:0]};

    assign link_fwd_ready_and = fwd_fifo_ready && (state_q == E_RUCHE_ACTIVE)
                                && (outstanding_q < max_cnt_lp);

    bsg_manycore_ruche_x_edge_fifo #(.width_p(fwd_width_lp)) fwd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (rst_n_sync),
        .v_i       (link_fwd_v & link_fwd_ready_and),
        .data_i    (fwd_injected),
        .ready_o   (fwd_fifo_ready),
        .v_o       (fwd_v_o),
        .data_o    (fwd_data_o),
        .yumi_i    (fwd_yumi_i)
    );

    assign rev_ready_o = rev_fifo_ready && (state_q != E_RUCHE_RESET);
    assign rev_enq     = rev_v_i & rev_ready_o;

    bsg_manycore_ruche_x_edge_fifo #(.width_p(rev_width_lp)) rev_fifo (
        .clk_i     (clk_i),
        .reset_n_i (rst_n_sync),
        .v_i       (rev_enq),
        .data_i    (rev_data_i),
        .ready_o   (rev_fifo_ready),
        .v_o       (rev_fifo_v),
        .data_o    (rev_fifo_data),
        .yumi_i    (rev_fifo_v & link_rev_ready_and)
    );

    assign rev_link_data = {rev_fifo_data[rev_width_lp-1:off_rev_hi_lp],
                            rev_fifo_data[x_cord_width_p-1:0]};

    assign ruche_link_o = {1'b0, {link_fwd_width_lp{1'b0}}, link_fwd_ready_and,
                           rev_fifo_v, rev_link_data, 1'b0};

    // Saturates at both ends; an inc and dec in the same cycle cancel.
    always_comb begin
        cnt_inc = fwd_yumi_i && fwd_v_o && (outstanding_q != max_cnt_lp)
                  && expects_response(bsg_manycore_packet_op_e'(fwd_data_o[off_op_lp +: packet_op_width_gp]),
                                      fwd_data_o[off_nr_lp]);
        cnt_dec = rev_fifo_v && link_rev_ready_and;
        outstanding_d = outstanding_q;
        if (cnt_inc && !cnt_dec) begin
            outstanding_d = outstanding_q + cnt_width_lp'(1);
        end else if (cnt_dec && !cnt_inc && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - cnt_width_lp'(1);
        end
    end

    assign link_idle = !fwd_v_o && !rev_fifo_v && (outstanding_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            E_RUCHE_RESET:   state_d = E_RUCHE_ACTIVE;
            E_RUCHE_ACTIVE:  if (drain_i) state_d = E_RUCHE_DRAIN;
            E_RUCHE_DRAIN: begin
                if (!drain_i) begin
                    state_d = E_RUCHE_ACTIVE;
                end else if (link_idle) begin
                    state_d = E_RUCHE_DRAINED;
                end
            end
            E_RUCHE_DRAINED: if (!drain_i) state_d = E_RUCHE_ACTIVE;
            default:         state_d = E_RUCHE_RESET;
        endcase
        drained_d = (state_d == E_RUCHE_DRAINED);
    end

    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q       <= E_RUCHE_RESET;
            outstanding_q <= '0;
            drained_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drained_q     <= drained_d;
        end
    end

    assign drained_o     = drained_q;
    assign outstanding_o = outstanding_q;

    always_ff @(posedge clk_i) begin
        if (rst_n_sync && cnt_dec && !cnt_inc) begin
            assert (outstanding_q != '0)
            else $error("ruche_x edge: rev response with no outstanding request");
        end
    end

`ifdef BSG_MANYCORE_RUCHE_EDGE_Y_CHECK_EN
    logic bad_y_r, bad_y_d;
    logic rev_y_mismatch;

    assign rev_y_mismatch = (rev_data_i[off_rev_y_lp +: y_cord_width_p] != my_y_i);

    always_comb begin
        bad_y_d = bad_y_r | (rev_enq & rev_y_mismatch);
    end

    always_ff @(posedge clk_i or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            bad_y_r <= 1'b0;
        end else begin
            bad_y_r <= bad_y_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_sync && rev_enq) begin
            assert (!rev_y_mismatch)
            else $error("ruche_x edge: rev dest_y %0d differs from my_y %0d",
                        rev_data_i[off_rev_y_lp +: y_cord_width_p], my_y_i);
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_ruche_x_edge_endpoint.sv
// Directed bench for the ruche_x edge endpoint: reset, src_y injection, dest_y strip,
// backpressure ordering, drain handshake, credit limit and mid-stream reset.
module tb_bsg_manycore_ruche_x_edge_endpoint;
    import bsg_manycore_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int MAXC = 4;
    localparam int FW = 35;
    localparam int FL = 31;
    localparam int RW = 18;
    localparam int RL = 14;
    localparam int SW = FL + RL + 4;
    localparam int CW = 3;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [YW-1:0] my_y_i;
    logic [SW-1:0] ruche_link_i;
    logic [SW-1:0] ruche_link_o;
    logic          fwd_v_o;
    logic [FW-1:0] fwd_data_o;
    logic          fwd_yumi_i;
    logic          rev_v_i;
    logic [RW-1:0] rev_data_i;
    logic          rev_ready_o;
    logic          drain_i;
    logic          drained_o;
    logic [CW-1:0] outstanding_o;

    logic          lfwd_v;
    logic [FL-1:0] lfwd_data;
    logic          lrev_ready;
    logic          link_fwd_ready, link_rev_v;
    logic [RL-1:0] link_rev_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    assign ruche_link_i   = {lfwd_v, lfwd_data, 1'b0, 1'b0, {RL{1'b0}}, lrev_ready};
    assign link_fwd_ready = ruche_link_o[RL+2];
    assign link_rev_v     = ruche_link_o[RL+1];
    assign link_rev_data  = ruche_link_o[RL:1];

    bsg_manycore_ruche_x_edge_endpoint #(
        .addr_width_p      (AW),
        .data_width_p      (DW),
        .x_cord_width_p    (XW),
        .y_cord_width_p    (YW),
        .max_out_credits_p (MAXC)
    ) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .my_y_i        (my_y_i),
        .ruche_link_i  (ruche_link_i),
        .ruche_link_o  (ruche_link_o),
        .fwd_v_o       (fwd_v_o),
        .fwd_data_o    (fwd_data_o),
        .fwd_yumi_i    (fwd_yumi_i),
        .rev_v_i       (rev_v_i),
        .rev_data_i    (rev_data_i),
        .rev_ready_o   (rev_ready_o),
        .drain_i       (drain_i),
        .drained_o     (drained_o),
        .outstanding_o (outstanding_o)
    );

    function automatic logic [FL-1:0] link_fwd(input logic [7:0] addr, input logic [1:0] op,
                                               input logic nr, input logic [7:0] data,
                                               input logic [3:0] sx, input logic [3:0] y,
                                               input logic [3:0] x);
        return {addr, op, nr, data, sx, y, x};
    endfunction

    function automatic logic [FW-1:0] full_fwd(input logic [7:0] addr, input logic [1:0] op,
                                               input logic nr, input logic [7:0] data,
                                               input logic [3:0] sy, input logic [3:0] sx,
                                               input logic [3:0] y, input logic [3:0] x);
        return {addr, op, nr, data, sy, sx, y, x};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Push one link fwd packet, check its injected form at the head, then consume it.
    task automatic apply_stimulus(input logic [FL-1:0] lpkt, input logic [FW-1:0] exp,
                                  input string tag);
        lfwd_v    = 1'b1;
        lfwd_data = lpkt;
        tick();
        lfwd_v = 1'b0;
        check_output({tag, "_v"}, 64'(fwd_v_o), 64'd1);
        check_output({tag, "_data"}, 64'(fwd_data_o), 64'(exp));
        fwd_yumi_i = 1'b1;
        tick();
        fwd_yumi_i = 1'b0;
    endtask

    initial begin
        reset_n_i  = 1'b0;
        my_y_i     = 4'd9;
        lfwd_v     = 1'b0;
        lfwd_data  = '0;
        lrev_ready = 1'b0;
        fwd_yumi_i = 1'b0;
        rev_v_i    = 1'b0;
        rev_data_i = '0;
        drain_i    = 1'b0;

        repeat (5) tick();
        check_output("rst_fwd_v", 64'(fwd_v_o), 64'd0);
        check_output("rst_rev_ready", 64'(rev_ready_o), 64'd0);
        check_output("rst_drained", 64'(drained_o), 64'd0);
        check_output("rst_link_fwd_ready", 64'(link_fwd_ready), 64'd0);
        check_output("rst_link_rev_v", 64'(link_rev_v), 64'd0);
        check_output("rst_outstanding", 64'(outstanding_o), 64'd0);

        // First sampling edge is cycle 0; ACTIVE appears at cycle 2.
        reset_n_i = 1'b1;
        tick();
        tick();
        check_output("sync_still_reset", 64'(rev_ready_o), 64'd0);
        tick();
        check_output("active_rev_ready", 64'(rev_ready_o), 64'd1);
        check_output("active_link_fwd_ready", 64'(link_fwd_ready), 64'd1);

        lfwd_v    = 1'b1;
        lfwd_data = link_fwd(8'h3c, e_remote_load, 1'b0, 8'h5a, 4'h2, 4'h1, 4'h0);
        check_output("rx_no_bypass", 64'(fwd_v_o), 64'd0);
        tick();
        lfwd_v = 1'b0;
        check_output("rx_latency_v", 64'(fwd_v_o), 64'd1);
        check_output("rx_src_y_inject", 64'(fwd_data_o),
                     64'(full_fwd(8'h3c, e_remote_load, 1'b0, 8'h5a, 4'd9, 4'h2, 4'h1, 4'h0)));
        check_output("rx_cnt_before_yumi", 64'(outstanding_o), 64'd0);
        fwd_yumi_i = 1'b1;
        tick();
        fwd_yumi_i = 1'b0;
        check_output("load_cnt_inc", 64'(outstanding_o), 64'd1);
        check_output("rx_fifo_empty", 64'(fwd_v_o), 64'd0);

        apply_stimulus(link_fwd(8'h10, e_remote_store, 1'b0, 8'h77, 4'h1, 4'h2, 4'h3),
                       full_fwd(8'h10, e_remote_store, 1'b0, 8'h77, 4'd9, 4'h1, 4'h2, 4'h3),
                       "store");
        check_output("store_no_cnt", 64'(outstanding_o), 64'd1);

        lrev_ready = 1'b1;
        rev_v_i    = 1'b1;
        rev_data_i = {2'b01, 8'ha5, 4'd9, 4'h3};
        check_output("tx_rev_ready", 64'(rev_ready_o), 64'd1);
        tick();
        rev_v_i = 1'b0;
        check_output("tx_latency_v", 64'(link_rev_v), 64'd1);
        check_output("tx_dest_y_strip", 64'(link_rev_data), 64'({2'b01, 8'ha5, 4'h3}));
        tick();
        check_output("tx_cnt_dec", 64'(outstanding_o), 64'd0);
        check_output("tx_fifo_empty", 64'(link_rev_v), 64'd0);

        apply_stimulus(link_fwd(8'h01, e_remote_load, 1'b0, 8'h11, 4'h0, 4'h0, 4'h0),
                       full_fwd(8'h01, e_remote_load, 1'b0, 8'h11, 4'd9, 4'h0, 4'h0, 4'h0), "ld_a");
        apply_stimulus(link_fwd(8'h02, e_remote_load, 1'b0, 8'h22, 4'h1, 4'h1, 4'h1),
                       full_fwd(8'h02, e_remote_load, 1'b0, 8'h22, 4'd9, 4'h1, 4'h1, 4'h1), "ld_b");
        apply_stimulus(link_fwd(8'h03, e_remote_load, 1'b0, 8'h33, 4'h2, 4'h2, 4'h2),
                       full_fwd(8'h03, e_remote_load, 1'b0, 8'h33, 4'd9, 4'h2, 4'h2, 4'h2), "ld_c");
        check_output("three_loads_cnt", 64'(outstanding_o), 64'd3);

        lrev_ready = 1'b0;
        rev_v_i    = 1'b1;
        rev_data_i = {2'b00, 8'hc1, 4'd9, 4'h1};
        tick();
        rev_data_i = {2'b00, 8'hc2, 4'd9, 4'h2};
        tick();
        rev_data_i = {2'b00, 8'hc3, 4'd9, 4'h4};
        check_output("bp_rev_full", 64'(rev_ready_o), 64'd0);
        tick();
        check_output("bp_head_a", 64'(link_rev_data), 64'({2'b00, 8'hc1, 4'h1}));
        lrev_ready = 1'b1;
        tick();
        check_output("bp_head_b", 64'(link_rev_data), 64'({2'b00, 8'hc2, 4'h2}));
        check_output("bp_cnt_2", 64'(outstanding_o), 64'd2);
        tick();
        rev_v_i = 1'b0;
        check_output("bp_head_c", 64'(link_rev_data), 64'({2'b00, 8'hc3, 4'h4}));
        check_output("bp_cnt_1", 64'(outstanding_o), 64'd1);
        tick();
        check_output("bp_cnt_0", 64'(outstanding_o), 64'd0);
        check_output("bp_empty", 64'(link_rev_v), 64'd0);

        apply_stimulus(link_fwd(8'h04, e_remote_load, 1'b0, 8'h44, 4'h3, 4'h3, 4'h3),
                       full_fwd(8'h04, e_remote_load, 1'b0, 8'h44, 4'd9, 4'h3, 4'h3, 4'h3), "dr_a");
        apply_stimulus(link_fwd(8'h05, e_remote_load, 1'b0, 8'h55, 4'h4, 4'h4, 4'h4),
                       full_fwd(8'h05, e_remote_load, 1'b0, 8'h55, 4'd9, 4'h4, 4'h4, 4'h4), "dr_b");
        check_output("drain_cnt_2", 64'(outstanding_o), 64'd2);
        drain_i = 1'b1;
        tick();
        check_output("drain_rx_closed", 64'(link_fwd_ready), 64'd0);
        check_output("drain_rev_open", 64'(rev_ready_o), 64'd1);
        check_output("drain_not_done", 64'(drained_o), 64'd0);
        rev_v_i    = 1'b1;
        rev_data_i = {2'b01, 8'hd1, 4'd9, 4'h5};
        tick();
        rev_v_i = 1'b0;
        tick();
        check_output("drain_one_left", 64'(drained_o), 64'd0);
        rev_v_i    = 1'b1;
        rev_data_i = {2'b01, 8'hd2, 4'd9, 4'h6};
        tick();
        rev_v_i = 1'b0;
        tick();
        check_output("drain_at_last_hs", 64'(drained_o), 64'd0);
        check_output("drain_cnt_0", 64'(outstanding_o), 64'd0);
        tick();
        check_output("drained_rise", 64'(drained_o), 64'd1);
        drain_i = 1'b0;
        tick();
        check_output("undrain_drained", 64'(drained_o), 64'd0);
        check_output("undrain_rx_open", 64'(link_fwd_ready), 64'd1);

        apply_stimulus(link_fwd(8'h06, e_remote_load, 1'b0, 8'h61, 4'h5, 4'h5, 4'h5),
                       full_fwd(8'h06, e_remote_load, 1'b0, 8'h61, 4'd9, 4'h5, 4'h5, 4'h5), "mx_1");
        apply_stimulus(link_fwd(8'h07, e_remote_load, 1'b0, 8'h62, 4'h6, 4'h6, 4'h6),
                       full_fwd(8'h07, e_remote_load, 1'b0, 8'h62, 4'd9, 4'h6, 4'h6, 4'h6), "mx_2");
        apply_stimulus(link_fwd(8'h08, e_remote_load, 1'b0, 8'h63, 4'h7, 4'h7, 4'h7),
                       full_fwd(8'h08, e_remote_load, 1'b0, 8'h63, 4'd9, 4'h7, 4'h7, 4'h7), "mx_3");
        apply_stimulus(link_fwd(8'h09, e_remote_load, 1'b0, 8'h64, 4'h8, 4'h8, 4'h8),
                       full_fwd(8'h09, e_remote_load, 1'b0, 8'h64, 4'd9, 4'h8, 4'h8, 4'h8), "mx_4");
        check_output("max_cnt", 64'(outstanding_o), 64'd4);
        check_output("max_rx_closed", 64'(link_fwd_ready), 64'd0);
        lfwd_v    = 1'b1;
        lfwd_data = link_fwd(8'h0a, e_remote_load, 1'b0, 8'h65, 4'h9, 4'h9, 4'h9);
        tick();
        check_output("max_blocked", 64'(fwd_v_o), 64'd0);
        rev_v_i    = 1'b1;
        rev_data_i = {2'b01, 8'he1, 4'd9, 4'h7};
        tick();
        rev_v_i = 1'b0;
        tick();
        check_output("max_cnt_after_resp", 64'(outstanding_o), 64'd3);
        check_output("max_rx_reopen", 64'(link_fwd_ready), 64'd1);
        tick();
        lfwd_v = 1'b0;
        check_output("max_fifth_v", 64'(fwd_v_o), 64'd1);
        check_output("max_fifth_data", 64'(fwd_data_o),
                     64'(full_fwd(8'h0a, e_remote_load, 1'b0, 8'h65, 4'd9, 4'h9, 4'h9, 4'h9)));

        lrev_ready = 1'b0;
        rev_v_i    = 1'b1;
        rev_data_i = {2'b01, 8'he2, 4'd9, 4'h8};
        tick();
        rev_v_i = 1'b0;
        check_output("pre_reset_rev_v", 64'(link_rev_v), 64'd1);
        reset_n_i = 1'b0;
        #1;
        check_output("midrst_fwd_v", 64'(fwd_v_o), 64'd0);
        check_output("midrst_rev_v", 64'(link_rev_v), 64'd0);
        check_output("midrst_cnt", 64'(outstanding_o), 64'd0);
        check_output("midrst_rev_ready", 64'(rev_ready_o), 64'd0);
        check_output("midrst_fwd_ready", 64'(link_fwd_ready), 64'd0);
        tick();
        reset_n_i = 1'b1;
        repeat (3) tick();
        check_output("post_rst_fwd_v", 64'(fwd_v_o), 64'd0);
        check_output("post_rst_rev_v", 64'(link_rev_v), 64'd0);
        check_output("post_rst_cnt", 64'(outstanding_o), 64'd0);
        check_output("post_rst_active", 64'(rev_ready_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
